// File: rtl/state_dump_reader.sv
// Captures a snapshot of the datapath registers and streams it out as a 7-byte
// frame (header, five payload bytes, checksum) over a valid/ready byte channel.
module state_dump_reader #(
    parameter logic [7:0] HDR = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  acc_in,
    input  logic [11:0] pc_in,
    input  logic [18:0] ir_in,
    input  logic        c_in,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t      state;
    logic [39:0] snap;
    logic [2:0]  idx;
    logic [7:0]  chk;
    logic [7:0]  next_byte;

    always_comb begin
        chk = snap[7:0] + snap[15:8] + snap[23:16] + snap[31:24] + snap[39:32];
    end

    // Byte that follows the one at idx; loaded into tx_data when idx transfers.
    always_comb begin
        next_byte = chk;
        case (idx)
            3'd0:    next_byte = snap[7:0];
            3'd1:    next_byte = snap[15:8];
            3'd2:    next_byte = snap[23:16];
            3'd3:    next_byte = snap[31:24];
            3'd4:    next_byte = snap[39:32];
            default: next_byte = chk;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            snap     <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap     <= {c_in, ir_in, pc_in, acc_in};
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= HDR;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx == 3'd6) begin
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            idx     <= idx + 3'd1;
                            tx_data <= next_byte;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
